// File: rtl/axi_pkg.sv
// Shared AXI4-Lite definitions for the memory responder slice.
// Contents: response codes, data/strobe widths, read-channel state type.
// No ports; imported by the interface, the responder top and the memory.
package axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

endpackage

// File: rtl/axi_mem_responder_if.sv
// AXI4-Lite bus bundle between a 64-bit master and the memory responder.
// Ports: AR/R read channels, AW/W/B write channels.
// Modports: master drives addresses/data/ready-for-response, slave the reverse.
interface axi_mem_responder_if;
  import axi_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/mem_bytewise_64.sv
// 64-bit word memory, one byte-enabled write port and one registered read port.
// Ports: clk; we/waddr/wdata/wstrb write side; re/raddr/rdata read side.
// A read and write to the same word on the same edge returns the old word.
module mem_bytewise_64
  import axi_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Contents are deliberately never reset so they survive a bus reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4-Lite slave memory model with byte strobes, programmable read latency,
// SLVERR outside the address window and wrap/saturate transaction counters.
// Ports: aclk, aresetn, s_axi (slave bus), rd_count, wr_count, err_count.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int          DEPTH_LOG2   = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1              // 0..15
) (
  input  logic                aclk,
  input  logic                aresetn,
  axi_mem_responder_if.slave  s_axi,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count,
  output logic [15:0]         err_count
);

  localparam logic [31:0] WIN_BYTES = 32'd8 << DEPTH_LOG2;
  localparam logic [3:0]  LAT       = 4'(READ_LATENCY);

  // ---------------- write path ----------------
  logic              aw_full, w_full, bvalid_q;
  logic [31:0]       aw_addr;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic [1:0]        bresp_q;
  logic [31:0]       wr_off;
  logic              wr_in_win, aw_hs, w_hs, b_hs, commit;

  assign wr_off    = aw_addr - BASE_ADDR;
  assign wr_in_win = wr_off < WIN_BYTES;

  assign s_axi.awready = !aw_full;
  assign s_axi.wready  = !w_full;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;

  assign aw_hs  = s_axi.awvalid && !aw_full;
  assign w_hs   = s_axi.wvalid && !w_full;
  assign b_hs   = bvalid_q && s_axi.bready;
  // Both halves present and no response outstanding: commit this edge.
  assign commit = aw_full && w_full && !bvalid_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= s_axi.awaddr;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      // Holding registers stay full until B retires, which keeps both
      // ready signals low for the whole response phase.
      if (b_hs) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b0;
        bresp_q  <= RESP_OKAY;
      end else if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_win ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // ---------------- read path ----------------
  rd_state_t         state, state_nxt;
  logic [3:0]        lat_cnt;
  logic [31:0]       ar_addr;
  logic [1:0]        rresp_q;
  logic [31:0]       rd_off;
  logic              rd_in_win, ar_hs, r_hs, rd_sample, rvalid_int;
  logic [DATA_W-1:0] mem_q;

  assign rd_off    = ar_addr - BASE_ADDR;
  assign rd_in_win = rd_off < WIN_BYTES;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= R_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE:  if (s_axi.arvalid)  state_nxt = R_WAIT;
      R_WAIT:  if (lat_cnt == 4'd0) state_nxt = R_RESP;
      R_RESP:  if (s_axi.rready)   state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = (state == R_IDLE);
    rvalid_int    = (state == R_RESP);
    rd_sample     = (state == R_WAIT) && (lat_cnt == 4'd0);
  end

  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign r_hs  = rvalid_int && s_axi.rready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lat_cnt <= '0;
      ar_addr <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        ar_addr <= s_axi.araddr;
        lat_cnt <= LAT;
      end else if (state == R_WAIT && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (rd_sample)  rresp_q <= rd_in_win ? RESP_OKAY : RESP_SLVERR;
      else if (r_hs)  rresp_q <= RESP_OKAY;
    end
  end

  // The memory's read register only loads on rd_sample, so data is stable
  // through backpressure; masking gives zero when idle or on SLVERR.
  assign s_axi.rvalid = rvalid_int;
  assign s_axi.rresp  = rresp_q;
  assign s_axi.rdata  = (rvalid_int && rresp_q == RESP_OKAY) ? mem_q : '0;

  mem_bytewise_64 #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk   (aclk),
    .we    (commit && wr_in_win),
    .waddr (wr_off[DEPTH_LOG2+2:3]),
    .wdata (w_data),
    .wstrb (w_strb),
    .re    (rd_sample),
    .raddr (rd_off[DEPTH_LOG2+2:3]),
    .rdata (mem_q)
  );

  // ---------------- counters ----------------
  logic [16:0] err_sum;

  always_comb begin
    err_sum = {1'b0, err_count}
            + {16'd0, (r_hs && rresp_q == RESP_SLVERR)}
            + {16'd0, (b_hs && bresp_q == RESP_SLVERR)};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      if (r_hs) rd_count <= rd_count + 16'd1;
      if (b_hs) wr_count <= wr_count + 16'd1;
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: table of write/read vectors plus
// hand sequences for latency, channel ordering, backpressure and mid-write reset.
// Expected responses are queued at stimulus time and popped when the DUT responds.
module tb_axi_mem_responder;
  import axi_pkg::*;

  localparam int RL = 1;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] rd_count, wr_count, err_count;

  axi_mem_responder_if bus();

  axi_mem_responder #(
    .DEPTH_LOG2(10), .BASE_ADDR(32'h0000_0000), .READ_LATENCY(RL)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_axi     (bus),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .err_count (err_count)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int exp_rd = 0, exp_wr = 0, exp_err = 0;
  logic [63:0] model [int];
  logic [1:0]  bq [$];
  logic [65:0] rq [$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
    logic [63:0] rdata;
  } vec_t;
  vec_t vecs [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    int k;
    logic [63:0] w;
    k = int'(a[12:3]);
    w = model.exists(k) ? model[k] : 64'h0;
    for (int i = 0; i < 8; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    model[k] = w;
  endfunction

  function automatic logic [63:0] model_read(input logic [31:0] a);
    int k;
    k = int'(a[12:3]);
    return model.exists(k) ? model[k] : 64'h0;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_rd_count"},  64'(rd_count),  64'(exp_rd));
    check({tag, "_wr_count"},  64'(wr_count),  64'(exp_wr));
    check({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           input logic [1:0] er, input int aw_dly, input int w_dly);
    bit aw_done, w_done;
    int cyc, lat;
    logic [1:0] exp_b;
    aw_done = 0; w_done = 0; cyc = 0; lat = 0;
    if (er == RESP_OKAY) model_write(a, d, s);
    bq.push_back(er);
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge aclk);
      bus.awaddr  = a;
      bus.wdata   = d;
      bus.wstrb   = s;
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready)   w_done = 1;
      cyc++;
    end
    check("wr_accept", 64'(aw_done && w_done), 64'd1);
    while (1) begin
      @(negedge aclk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (bus.bvalid || lat > 20) break;
      lat++;
    end
    exp_b = bq.pop_front();
    check("b_latency", 64'(lat), 64'd1);
    check("b_resp", 64'(bus.bresp), 64'(exp_b));
    check("ready_low_during_b", 64'({bus.awready, bus.wready}), 64'd0);
    bus.bready = 1'b1;
    exp_wr++;
    if (exp_b == RESP_SLVERR) exp_err++;
    @(negedge aclk);
    bus.bready = 1'b0;
    check("b_cleared", 64'(bus.bvalid), 64'd0);
    check("ready_back", 64'({bus.awready, bus.wready}), 64'd3);
  endtask

  task automatic read_txn(input logic [31:0] a, input logic [63:0] exp_d, input logic [1:0] exp_r,
                          input int rdy_dly);
    bit ok;
    int lat;
    logic [65:0] e;
    ok = 0; lat = 0;
    rq.push_back({exp_r, exp_d});
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge aclk);
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      ok = bus.arready;
    end
    check("ar_accept", 64'(ok), 64'd1);
    while (1) begin
      @(negedge aclk);
      bus.arvalid = 1'b0;
      if (bus.rvalid || lat > 40) break;
      lat++;
    end
    e = rq.pop_front();
    check("r_latency", 64'(lat), 64'(RL + 1));
    for (int i = 0; i < rdy_dly; i++) begin
      check("r_hold_valid", 64'(bus.rvalid), 64'd1);
      check("r_hold_data", bus.rdata, e[63:0]);
      check("r_hold_resp", 64'(bus.rresp), 64'(e[65:64]));
      check("r_hold_arready", 64'(bus.arready), 64'd0);
      @(negedge aclk);
    end
    check("r_data", bus.rdata, e[63:0]);
    check("r_resp", 64'(bus.rresp), 64'(e[65:64]));
    bus.rready = 1'b1;
    exp_rd++;
    if (e[65:64] == RESP_SLVERR) exp_err++;
    @(negedge aclk);
    bus.rready = 1'b0;
    check("r_cleared", 64'({bus.rvalid, bus.rdata, bus.rresp}), 64'd0);
    check("arready_back", 64'(bus.arready), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [31:0] a;

    aresetn     = 1'b0;
    bus.araddr  = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr  = '0; bus.awvalid = 1'b0; bus.wdata  = '0;
    bus.wstrb   = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst_readies", 64'({bus.arready, bus.awready, bus.wready}), 64'd7);
    check("rst_valids", 64'({bus.rvalid, bus.bvalid}), 64'd0);
    check("rst_rdata", bus.rdata, 64'd0);
    check("rst_resps", 64'({bus.rresp, bus.bresp}), 64'd0);
    aresetn = 1'b1;
    check_counters("rst");

    // Single write then read with the default one-cycle latency.
    write_txn(32'h10, 64'h1122_3344_5566_7788, 8'hFF, RESP_OKAY, 0, 0);
    read_txn(32'h10, 64'h1122_3344_5566_7788, RESP_OKAY, 0);
    check("first_wr_count", 64'(wr_count), 64'd1);
    check("first_rd_count", 64'(rd_count), 64'd1);

    // Out-of-window read held under backpressure for 5 cycles.
    read_txn(32'h2000, 64'h0, RESP_SLVERR, 5);
    check("oor_err_count", 64'(err_count), 64'd1);

    vecs.push_back('{1, 32'h18,   64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, RESP_OKAY,   64'h0});
    vecs.push_back('{1, 32'h18,   64'h0,                   8'h05, RESP_OKAY,   64'h0});
    vecs.push_back('{0, 32'h18,   64'h0,                   8'h00, RESP_OKAY,   64'hFFFF_FFFF_FF00_FF00});
    vecs.push_back('{1, 32'h20,   64'h0123_4567_89AB_CDEF, 8'hFF, RESP_OKAY,   64'h0});
    vecs.push_back('{1, 32'h27,   64'hAAAA_AAAA_AAAA_AAAA, 8'h80, RESP_OKAY,   64'h0});
    vecs.push_back('{0, 32'h24,   64'h0,                   8'h00, RESP_OKAY,   64'hAA23_4567_89AB_CDEF});
    vecs.push_back('{1, 32'h28,   64'hCAFE_F00D_1234_5678, 8'hFF, RESP_OKAY,   64'h0});
    vecs.push_back('{1, 32'h28,   64'hDEAD_BEEF_DEAD_BEEF, 8'h00, RESP_OKAY,   64'h0});
    vecs.push_back('{0, 32'h28,   64'h0,                   8'h00, RESP_OKAY,   64'hCAFE_F00D_1234_5678});
    vecs.push_back('{1, 32'h1FF8, 64'h5555_AAAA_3333_CCCC, 8'hFF, RESP_OKAY,   64'h0});
    vecs.push_back('{0, 32'h1FF8, 64'h0,                   8'h00, RESP_OKAY,   64'h5555_AAAA_3333_CCCC});
    vecs.push_back('{1, 32'h2000, 64'h1234_1234_1234_1234, 8'hFF, RESP_SLVERR, 64'h0});
    vecs.push_back('{0, 32'h2008, 64'h0,                   8'h00, RESP_SLVERR, 64'h0});
    foreach (vecs[i]) begin
      if (vecs[i].wr) write_txn(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, 0, 0);
      else            read_txn(vecs[i].addr, vecs[i].rdata, vecs[i].resp, 0);
    end
    check_counters("table");

    // Channel ordering: W three cycles ahead of AW, then both together.
    write_txn(32'h30, 64'h0A0B_0C0D_0E0F_1011, 8'hFF, RESP_OKAY, 3, 0);
    write_txn(32'h38, 64'h7766_5544_3322_1100, 8'hFF, RESP_OKAY, 0, 0);
    read_txn(32'h30, model_read(32'h30), RESP_OKAY, 0);
    read_txn(32'h38, model_read(32'h38), RESP_OKAY, 0);

    // Byte-at-a-time writes as the channel master issues them.
    write_txn(32'h0, 64'h0807_0605_0403_0201, 8'hFF, RESP_OKAY, 0, 0);
    for (int i = 0; i < 4; i++) begin
      a = 32'h3 + 32'(i);
      b = 8'hA5 ^ 8'(4 - i);
      write_txn(a, {8{b}}, 8'(1 << a[2:0]), RESP_OKAY, 0, 0);
    end
    read_txn(32'h0, 64'h08A4_A7A6_A103_0201, RESP_OKAY, 0);
    check_counters("chan");

    // Reset between the AW and W handshakes.
    @(negedge aclk);
    bus.awaddr  = 32'h10;
    bus.awvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0;
    check("mid_aw_captured", 64'(bus.awready), 64'd0);
    aresetn = 1'b0;
    @(negedge aclk);
    check("mid_rst_bvalid", 64'(bus.bvalid), 64'd0);
    aresetn = 1'b1;
    exp_rd = 0; exp_wr = 0; exp_err = 0;
    @(negedge aclk);
    check("post_rst_readies", 64'({bus.awready, bus.wready}), 64'd3);
    check("post_rst_bvalid", 64'(bus.bvalid), 64'd0);
    check_counters("post_rst");
    read_txn(32'h10, model_read(32'h10), RESP_OKAY, 0);
    write_txn(32'h10, 64'hF0E1_D2C3_B4A5_9687, 8'h3C, RESP_OKAY, 0, 0);
    read_txn(32'h10, model_read(32'h10), RESP_OKAY, 0);
    check_counters("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4-Lite slave memory model; the responder end of the 64-bit M_AXI byte-access master in the channel block.
- Sits on the channel's m_axi_* port in simulation and bring-up designs and stands in for DDR/BRAM behind the interconnect.
- Honours wstrb byte lanes, adds programmable read latency, reports SLVERR for out-of-window addresses, and keeps transaction counters for the bench.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 64-bit words; the default 1024 words gives an 8 KiB window.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 8-byte aligned.
- READ_LATENCY, 1, extra wait cycles (0..15) inserted between the AR handshake and rvalid.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axi_arready  out  1  read address ready
- s_axi_araddr  in  32  read byte address
- s_axi_arvalid  in  1  read address valid
- s_axi_rready  in  1  read data ready
- s_axi_rdata  out  64  read data
- s_axi_rresp  out  2  read response: 00 OKAY, 10 SLVERR
- s_axi_rvalid  out  1  read data valid
- s_axi_awready  out  1  write address ready
- s_axi_awaddr  in  32  write byte address
- s_axi_awvalid  in  1  write address valid
- s_axi_wready  out  1  write data ready
- s_axi_wdata  in  64  write data
- s_axi_wstrb  in  8  byte-lane enables
- s_axi_wvalid  in  1  write data valid
- s_axi_bready  in  1  write response ready
- s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR
- s_axi_bvalid  out  1  write response valid
- rd_count  out  16  completed R handshakes, wraps
- wr_count  out  16  completed B handshakes, wraps
- err_count  out  16  SLVERR responses issued, saturates at 16'hFFFF

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - arready, awready, wready = 1.
  - rvalid, bvalid = 0.
  - rdata = 0; rresp, bresp = 00.
  - All counters = 0.
  - Memory contents are not cleared.
- Address decode:
  - offset = addr - BASE_ADDR.
  - In range when offset < 8 << DEPTH_LOG2.
  - word index = offset[DEPTH_LOG2+2:3]; addr[2:0] is ignored.
- Write path:
  - AW and W are captured independently into one-entry holding registers, in either order or in the same cycle.
  - awready drops the cycle after an AW handshake; wready drops the cycle after a W handshake.
  - Commit occurs the cycle after both holding registers are full.
    - In range: write each byte lane i with wstrb[i]=1; bresp=00.
    - Out of range: no write; bresp=10.
    - bvalid rises on the commit cycle.
  - bvalid and bresp hold until bready. The B handshake clears the holding registers, and awready/wready return to 1 on the following cycle.
  - wstrb = 0 is a legal OKAY no-op.
- Read path, state machine R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready = 1. The AR handshake latches the address, loads the latency counter with READ_LATENCY and deasserts arready.
  - R_WAIT: the counter decrements each cycle. At 0, sample memory into rdata and set rvalid.
  - Latency: rvalid rises exactly READ_LATENCY+1 cycles after the AR handshake cycle.
  - Out of range: rdata = 0, rresp = 10.
  - R_RESP: rdata and rresp stable while rvalid && !rready. The R handshake clears rvalid, rdata and rresp, returns to R_IDLE, and arready = 1 the next cycle.
- Read and write paths are fully independent. Same word, same cycle (write commit and read sample): the read returns the old data.
- Counters:
  - rd_count and wr_count increment on the R and B handshakes respectively.
  - err_count increments on any SLVERR handshake, R or B. Simultaneous R and B errors add 2, saturating.
- Reset asserted mid-transaction: all pending transactions are discarded and no partial write is committed. After release the block accepts new traffic on the first clock edge.

Decomposition:
- Shared package axi_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - AXI data/strobe width constants (64/8).
  - The read-state enum.
- One sub-module, mem_bytewise_64: single write port with 8 byte enables, single synchronous read port, DEPTH_LOG2 deep, read-before-write.
- Decode, handshakes and counters stay in the top.

Test Plan:
- Single write then read:
  - Write 0x0000_0010 with wdata=64'h1122_3344_5566_7788, wstrb=FF, then read 0x10 with READ_LATENCY=1.
  - Required: bresp=00, rdata=64'h1122_3344_5566_7788, rvalid 2 cycles after AR, wr_count=1, rd_count=1.
- Byte-lane masking:
  - Preload 0x18 with all-FF, then write 64'h0, wstrb=8'h05.
  - Required: readback 64'hFFFF_FFFF_FF00_FF00.
- Channel ordering:
  - W presented 3 cycles before AW; then AW and W in the same cycle.
  - Required: each bvalid exactly 1 cycle after the later handshake, with no awready/wready while bvalid is high.
- Out of range and backpressure:
  - Read at BASE_ADDR+0x2000 with rready held low for 5 cycles.
  - Required: rresp=10, rdata=0 stable for all 5 cycles, arready=0 throughout, err_count=1.
- Driven by axi_channel:
  - Count=4 byte writes from addr 0x3, data 0xA5.
  - Required: bytes 3..6 hold A5^04, A5^03, A5^02, A5^01; neighbouring bytes are untouched.
- Reset mid-write:
  - Assert aresetn=0 after the AW handshake but before W.
  - Required: no memory change, bvalid=0, awready=wready=1 after release, and a subsequent write completes normally.
